// File: rtl/cbuf_pkg.sv
// Shared types and constants for the CBUF-mode acquisition path.
// Widths, mux tags and the fill sequencer state encoding.
package cbuf_pkg;

  localparam int ADR_W     = 23;
  localparam int FNUM_W    = 24;
  localparam int NB_W      = 14;
  localparam int OVH_WORDS = 3;

  localparam logic [2:0] TAG_FILL  = 3'd1;
  localparam logic [2:0] TAG_WFM   = 3'd2;
  localparam logic [2:0] TAG_DAT   = 3'd3;
  localparam logic [2:0] TAG_CKSUM = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_HDR,
    S_WFM_HDR,
    S_DATA,
    S_CKSUM,
    S_DONE
  } state_t;

endpackage

// File: rtl/cbuf_fill_bookkeeper.sv
// Per-channel fill number and DDR3 burst start address.
// Both advance together once per completed fill, wrapping at their widths.
module cbuf_fill_bookkeeper #(
  parameter int ADR_W     = cbuf_pkg::ADR_W,
  parameter int FNUM_W    = cbuf_pkg::FNUM_W,
  parameter int NB_W      = cbuf_pkg::NB_W,
  parameter int OVH_WORDS = cbuf_pkg::OVH_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [NB_W-1:0]   num_bursts,
  output logic [FNUM_W-1:0] fill_num,
  output logic [ADR_W-1:0]  burst_start_adr
);

  // Truncating the operands first keeps the sum modulo 2^ADR_W
  logic [ADR_W-1:0] adr_next;

  assign adr_next = burst_start_adr
                  + ADR_W'(num_bursts)
                  + ADR_W'(OVH_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_num        <= '0;
      burst_start_adr <= '0;
    end else if (advance) begin
      fill_num        <= fill_num + FNUM_W'(1);
      burst_start_adr <= adr_next;
    end
  end

endmodule

// File: rtl/cbuf_acq_sequencer.sv
// CBUF-mode fill sequencer: drives the one-hot ADC data mux selects
// and the DDR3 write-FIFO strobe for one channel.
module cbuf_acq_sequencer #(
  parameter int ADR_W     = cbuf_pkg::ADR_W,
  parameter int FNUM_W    = cbuf_pkg::FNUM_W,
  parameter int NB_W      = cbuf_pkg::NB_W,
  parameter int OVH_WORDS = cbuf_pkg::OVH_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [1:0]        fill_type_in,
  input  logic [NB_W-1:0]   async_num_bursts,
  input  logic              fifo_afull,
  input  logic              dat_valid,
  output logic              dat_ready,
  output logic              select_fill_hdr,
  output logic              select_waveform_hdr,
  output logic              select_dat,
  output logic              select_checksum,
  output logic              checksum_update,
  output logic              fifo_wr_en,
  output logic [1:0]        fill_type,
  output logic [NB_W-1:0]   num_bursts,
  output logic [ADR_W-1:0]  burst_start_adr,
  output logic [FNUM_W-1:0] fill_num,
  output logic              busy,
  output logic              fill_done,
  output logic              trig_overrun
);

  import cbuf_pkg::*;

  state_t          state;
  state_t          state_nxt;
  logic [NB_W-1:0] cnt;
  logic [NB_W-1:0] cnt_nxt;
  logic            accept;
  logic            any_sel;

  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    accept              = 1'b0;
    dat_ready           = 1'b0;
    select_fill_hdr     = 1'b0;
    select_waveform_hdr = 1'b0;
    select_dat          = 1'b0;
    select_checksum     = 1'b0;
    checksum_update     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (trig && fill_type_in != 2'd0) begin
          accept    = 1'b1;
          state_nxt = S_FILL_HDR;
        end
      end
      S_FILL_HDR: begin
        if (!fifo_afull) begin
          select_fill_hdr = 1'b1;
          state_nxt       = S_WFM_HDR;
        end
      end
      S_WFM_HDR: begin
        if (!fifo_afull) begin
          select_waveform_hdr = 1'b1;
          state_nxt = (num_bursts != '0) ? S_DATA : S_CKSUM;
        end
      end
      S_DATA: begin
        dat_ready = !fifo_afull;
        if (dat_valid && !fifo_afull) begin
          select_dat      = 1'b1;
          checksum_update = 1'b1;
          // Leaving through CKSUM gives the checksum one cycle to settle
          if (cnt == num_bursts - NB_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = S_CKSUM;
          end else begin
            cnt_nxt = cnt + NB_W'(1);
          end
        end
      end
      S_CKSUM: begin
        if (!fifo_afull) begin
          select_checksum = 1'b1;
          state_nxt       = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign any_sel = select_fill_hdr | select_waveform_hdr
                 | select_dat | select_checksum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fill_type    <= '0;
      num_bursts   <= '0;
      busy         <= 1'b0;
      fill_done    <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      fifo_wr_en   <= any_sel;
      fill_done    <= (state == S_DONE);
      trig_overrun <= trig && (state != S_IDLE);
      if (accept) begin
        fill_type  <= fill_type_in;
        num_bursts <= async_num_bursts;
        busy       <= 1'b1;
      end else if (state == S_DONE) begin
        busy <= 1'b0;
      end
    end
  end

  cbuf_fill_bookkeeper #(
    .ADR_W     (ADR_W),
    .FNUM_W    (FNUM_W),
    .NB_W      (NB_W),
    .OVH_WORDS (OVH_WORDS)
  ) u_book (
    .clk             (clk),
    .rst             (rst),
    .advance         (state == S_DONE),
    .num_bursts      (num_bursts),
    .fill_num        (fill_num),
    .burst_start_adr (burst_start_adr)
  );

endmodule

// File: tb/tb_cbuf_acq_sequencer.sv
// Directed bench for cbuf_acq_sequencer: per-cycle vector table plus
// a narrow-width instance exercising fill number / address wrap.
module tb_cbuf_acq_sequencer;

  localparam int NB_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            trig;
  logic            trig_w;
  logic [1:0]      fill_type_in;
  logic [NB_W-1:0] async_num_bursts;
  logic            fifo_afull;
  logic            dat_valid;

  logic            dat_ready, sel_fh, sel_wh, sel_d, sel_ck;
  logic            cku, wr_en, busy, fill_done, ovr;
  logic [1:0]      fill_type;
  logic [NB_W-1:0] num_bursts;
  logic [22:0]     adr;
  logic [23:0]     fill_num;

  logic            rdy_w, fh_w, wh_w, d_w, ck_w;
  logic            cku_w, wr_w, busy_w, done_w, ovr_w;
  logic [1:0]      ft_w;
  logic [NB_W-1:0] nb_w;
  logic [2:0]      adr_w;
  logic [1:0]      fnum_w;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cbuf_acq_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .trig                (trig),
    .fill_type_in        (fill_type_in),
    .async_num_bursts    (async_num_bursts),
    .fifo_afull          (fifo_afull),
    .dat_valid           (dat_valid),
    .dat_ready           (dat_ready),
    .select_fill_hdr     (sel_fh),
    .select_waveform_hdr (sel_wh),
    .select_dat          (sel_d),
    .select_checksum     (sel_ck),
    .checksum_update     (cku),
    .fifo_wr_en          (wr_en),
    .fill_type           (fill_type),
    .num_bursts          (num_bursts),
    .burst_start_adr     (adr),
    .fill_num            (fill_num),
    .busy                (busy),
    .fill_done           (fill_done),
    .trig_overrun        (ovr)
  );

  cbuf_acq_sequencer #(
    .ADR_W  (3),
    .FNUM_W (2),
    .NB_W   (NB_W)
  ) dut_w (
    .clk                 (clk),
    .rst                 (rst),
    .trig                (trig_w),
    .fill_type_in        (fill_type_in),
    .async_num_bursts    (async_num_bursts),
    .fifo_afull          (fifo_afull),
    .dat_valid           (dat_valid),
    .dat_ready           (rdy_w),
    .select_fill_hdr     (fh_w),
    .select_waveform_hdr (wh_w),
    .select_dat          (d_w),
    .select_checksum     (ck_w),
    .checksum_update     (cku_w),
    .fifo_wr_en          (wr_w),
    .fill_type           (ft_w),
    .num_bursts          (nb_w),
    .burst_start_adr     (adr_w),
    .fill_num            (fnum_w),
    .busy                (busy_w),
    .fill_done           (done_w),
    .trig_overrun        (ovr_w)
  );

  // exp: {rdy, fh, wh, d, ck, cku, wr, busy, done, ovr}
  typedef struct {
    string      name;
    logic       rst;
    logic       trig;
    logic [1:0] ft;
    int         nb;
    logic       af;
    logic       dv;
    logic [9:0] exp;
    int         fn;
    int         ad;
    int         lft;
    int         lnb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, logic r, logic t, logic [1:0] ft,
                              int nb, logic af, logic dv, logic [9:0] e,
                              int fn, int ad, int lft, int lnb);
    vec_t v;
    v.name = n; v.rst = r; v.trig = t; v.ft = ft; v.nb = nb;
    v.af = af; v.dv = dv; v.exp = e; v.fn = fn; v.ad = ad;
    v.lft = lft; v.lnb = lnb;
    return v;
  endfunction

  task automatic chk(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_w(input int nb, input int efn, input int eadr);
    int  writes;
    bit  seen;
    writes = 0;
    seen   = 0;
    @(negedge clk);
    async_num_bursts = NB_W'(nb);
    fill_type_in = 2'd1;
    fifo_afull = 1'b0;
    dat_valid = 1'b1;
    trig_w = 1'b1;
    @(negedge clk);
    trig_w = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      #1;
      if (!$onehot0({fh_w, wh_w, d_w, ck_w}) || cku_w != d_w
          || rdy_w != d_w) begin
        chk("w_onehot", int'({fh_w, wh_w, d_w, ck_w}), 0);
      end
      if (wr_w) writes++;
      if (done_w) seen = 1;
      else @(negedge clk);
    end
    chk("w_done_seen", int'(seen), 1);
    chk("w_writes", writes, nb + 3);
    chk("w_fill_num", int'(fnum_w), efn);
    chk("w_adr", int'(adr_w), eadr);
    chk("w_state", int'({busy_w, ovr_w, ft_w, nb_w}),
        int'({1'b0, 1'b0, 2'd1, NB_W'(nb)}));
  endtask

  initial begin
    logic [9:0] got;
    rst = 1'b1; trig = 1'b0; trig_w = 1'b0;
    fill_type_in = 2'd0; async_num_bursts = '0;
    fifo_afull = 1'b0; dat_valid = 1'b0;

    vq.push_back(mk("rst_state", 0,0,0,4,0,1, 10'b0_0000_0_0_0_0_0, 0,0,0,0));
    vq.push_back(mk("b_trig",    0,1,1,4,0,1, 10'b0_0000_0_0_0_0_0, 0,0,0,0));
    vq.push_back(mk("b_fh",      0,0,1,4,0,1, 10'b0_1000_0_0_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_wh",      0,0,1,4,0,1, 10'b0_0100_0_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_d0",      0,0,1,4,0,1, 10'b1_0010_1_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_d1",      0,0,1,4,0,1, 10'b1_0010_1_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_d2",      0,0,1,4,0,1, 10'b1_0010_1_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_d3",      0,0,1,4,0,1, 10'b1_0010_1_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_ck",      0,0,1,4,0,1, 10'b0_0001_0_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_done",    0,0,1,4,0,1, 10'b0_0000_0_1_1_0_0, 0,0,1,4));
    vq.push_back(mk("b_idle",    0,0,1,4,0,1, 10'b0_0000_0_0_0_1_0, 1,7,1,4));

    vq.push_back(mk("c_trig",    0,1,2,3,0,1, 10'b0_0000_0_0_0_0_0, 1,7,1,4));
    vq.push_back(mk("c_fh",      0,0,2,3,0,1, 10'b0_1000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af0",     0,0,2,3,1,1, 10'b0_0000_0_1_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af1",     0,0,2,3,1,1, 10'b0_0000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af2",     0,0,2,3,1,1, 10'b0_0000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af3",     0,0,2,3,1,1, 10'b0_0000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af4",     0,0,2,3,1,1, 10'b0_0000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_wh",      0,0,2,3,0,1, 10'b0_0100_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_d0",      0,0,2,3,0,1, 10'b1_0010_1_1_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af5",     0,0,2,3,1,1, 10'b0_0000_0_1_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_nodv",    0,0,2,3,0,0, 10'b1_0000_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_d1",      0,0,2,3,0,1, 10'b1_0010_1_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af6",     0,0,2,3,1,1, 10'b0_0000_0_1_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_d2",      0,0,2,3,0,1, 10'b1_0010_1_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_af7",     0,0,2,3,1,1, 10'b0_0000_0_1_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_ck",      0,0,2,3,0,1, 10'b0_0001_0_0_1_0_0, 1,7,2,3));
    vq.push_back(mk("c_done",    0,0,2,3,0,1, 10'b0_0000_0_1_1_0_0, 1,7,2,3));

    vq.push_back(mk("d_retrig",  0,1,1,0,0,1, 10'b0_0000_0_0_0_1_0, 2,13,2,3));
    vq.push_back(mk("d_fh",      0,0,1,0,0,1, 10'b0_1000_0_0_1_0_0, 2,13,1,0));
    vq.push_back(mk("d_wh",      0,0,1,0,0,1, 10'b0_0100_0_1_1_0_0, 2,13,1,0));
    vq.push_back(mk("d_ck",      0,0,1,0,0,1, 10'b0_0001_0_1_1_0_0, 2,13,1,0));
    vq.push_back(mk("d_done",    0,0,1,0,0,1, 10'b0_0000_0_1_1_0_0, 2,13,1,0));
    vq.push_back(mk("d_idle",    0,0,1,0,0,1, 10'b0_0000_0_0_0_1_0, 3,16,1,0));

    vq.push_back(mk("e_trig",    0,1,3,2,0,1, 10'b0_0000_0_0_0_0_0, 3,16,1,0));
    vq.push_back(mk("e_fh",      0,0,3,2,0,1, 10'b0_1000_0_0_1_0_0, 3,16,3,2));
    vq.push_back(mk("e_wh",      0,0,3,2,0,1, 10'b0_0100_0_1_1_0_0, 3,16,3,2));
    vq.push_back(mk("e_d0_trig", 0,1,3,7,0,1, 10'b1_0010_1_1_1_0_0, 3,16,3,2));
    vq.push_back(mk("e_d1_ovr",  0,0,3,7,0,1, 10'b1_0010_1_1_1_0_1, 3,16,3,2));
    vq.push_back(mk("e_ck",      0,0,3,7,0,1, 10'b0_0001_0_1_1_0_0, 3,16,3,2));
    vq.push_back(mk("e_done",    0,0,3,7,0,1, 10'b0_0000_0_1_1_0_0, 3,16,3,2));
    vq.push_back(mk("e_idle",    0,0,3,7,0,1, 10'b0_0000_0_0_0_1_0, 4,21,3,2));

    vq.push_back(mk("f_trig_ft0",0,1,0,5,0,1, 10'b0_0000_0_0_0_0_0, 4,21,3,2));
    vq.push_back(mk("f_after",   0,0,0,5,0,1, 10'b0_0000_0_0_0_0_0, 4,21,3,2));

    vq.push_back(mk("g_trig",    0,1,1,8,0,1, 10'b0_0000_0_0_0_0_0, 4,21,3,2));
    vq.push_back(mk("g_fh",      0,0,1,8,0,1, 10'b0_1000_0_0_1_0_0, 4,21,1,8));
    vq.push_back(mk("g_wh",      0,0,1,8,0,1, 10'b0_0100_0_1_1_0_0, 4,21,1,8));
    vq.push_back(mk("g_d0",      0,0,1,8,0,1, 10'b1_0010_1_1_1_0_0, 4,21,1,8));
    vq.push_back(mk("g_d1_rst",  1,0,1,8,0,1, 10'b1_0010_1_1_1_0_0, 4,21,1,8));
    vq.push_back(mk("g_post_rst",0,0,1,8,0,1, 10'b0_0000_0_0_0_0_0, 0,0,0,0));
    vq.push_back(mk("g_trig2",   0,1,1,1,0,1, 10'b0_0000_0_0_0_0_0, 0,0,0,0));
    vq.push_back(mk("g_fh2",     0,0,1,1,0,1, 10'b0_1000_0_0_1_0_0, 0,0,1,1));
    vq.push_back(mk("g_wh2",     0,0,1,1,0,1, 10'b0_0100_0_1_1_0_0, 0,0,1,1));
    vq.push_back(mk("g_d2",      0,0,1,1,0,1, 10'b1_0010_1_1_1_0_0, 0,0,1,1));
    vq.push_back(mk("g_ck2",     0,0,1,1,0,1, 10'b0_0001_0_1_1_0_0, 0,0,1,1));
    vq.push_back(mk("g_done2",   0,0,1,1,0,1, 10'b0_0000_0_1_1_0_0, 0,0,1,1));
    vq.push_back(mk("g_idle2",   0,0,1,1,0,1, 10'b0_0000_0_0_0_1_0, 1,4,1,1));

    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      trig = vq[i].trig;
      fill_type_in = vq[i].ft;
      async_num_bursts = NB_W'(vq[i].nb);
      fifo_afull = vq[i].af;
      dat_valid = vq[i].dv;
      #1;
      got = {dat_ready, sel_fh, sel_wh, sel_d, sel_ck,
             cku, wr_en, busy, fill_done, ovr};
      n_chk++;
      if (got !== vq[i].exp) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b want %b",
                 vq[i].name, got, vq[i].exp);
      end
      n_chk++;
      if (int'(fill_num) != vq[i].fn || int'(adr) != vq[i].ad
          || int'(fill_type) != vq[i].lft
          || int'(num_bursts) != vq[i].lnb) begin
        n_fail++;
        $display("FAIL %s latch: got fn=%0d adr=%0d ft=%0d nb=%0d want fn=%0d adr=%0d ft=%0d nb=%0d",
                 vq[i].name, fill_num, adr, fill_type, num_bursts,
                 vq[i].fn, vq[i].ad, vq[i].lft, vq[i].lnb);
      end
    end

    @(negedge clk);
    rst = 1'b1;
    trig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_w(3, 1, 6);
    run_w(5, 2, 6);
    run_w(5, 3, 6);
    run_w(1, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
